mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_req_valid/if_req_ready  in/out  1/1  fetch request handshake; fetch is read-only.
REQ-004 if_req_addr  in  `ALEN  fetch address.
REQ-005 if_resp_valid/if_resp_data/if_resp_fault  out  1/`XLEN/1  fetch response, one-cycle pulse.
REQ-006 if_flush  in  1  discard any outstanding or pending fetch.
REQ-007 ls_req_valid/ls_req_ready  in/out  1/1  load-store request handshake.
REQ-008 ls_req_addr/ls_req_write/ls_req_wdata/ls_req_wmask  in  `ALEN/1/`XLEN/(`XLEN/8)  load-store request fields.
REQ-009 ls_resp_valid/ls_resp_data/ls_resp_fault  out  1/`XLEN/1  load-store response, one-cycle pulse.
REQ-010 mem_req_valid/mem_req_ready  out/in  1/1  shared memory port request handshake.
REQ-011 mem_addr/mem_write/mem_wdata/mem_wmask  out  `ALEN/1/`XLEN/(`XLEN/8)  shared request fields.
REQ-012 mem_resp_valid/mem_resp_data/mem_resp_fault  in  1/`XLEN/1  shared response; never in the same cycle as the request handshake.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-014 IDLE: if_req_ready/ls_req_ready combinational; at most one asserted, and only for the granted valid requester.
REQ-015 Accept in IDLE latches addr/write/wdata/wmask and owner (IF or LS), then goes to ISSUE.
REQ-016 ISSUE: mem_req_valid=1 from registered fields, held stable until mem_req_ready, then goes to WAIT.
REQ-017 WAIT: on mem_resp_valid, register data/fault, pulse the owner's resp_valid next cycle, and return to IDLE.
REQ-018 Minimum occupancy: accept to resp_valid is 3 cycles with zero memory wait; a new accept is allowed in the same cycle resp_valid pulses.
REQ-019 Fetch requests always drive mem_write=0 and mem_wmask=0.
REQ-020 if_flush in IDLE: if_req_ready=0 that cycle.
REQ-021 if_flush while the owner is IF in ISSUE/WAIT sets a drop flag: the transaction completes on the memory side, but if_resp_valid is suppressed.
REQ-022 Drop flag clears on return to IDLE.
REQ-023 if_flush has no effect on LS-owned transactions.
REQ-024 mem_resp_valid outside WAIT is ignored.

Reset
REQ-025 Reset values: state=IDLE, mem_req_valid=0, both req_ready=0, both resp_valid=0, drop flag=0, rr pointer=IF-last.
REQ-026 Response data/fault and latched fields reset to don't-care.
REQ-027 Reset mid-transaction abandons it; no response is produced.

Configuration
REQ-028 MEM_ARB_ROUND_ROBIN_EN defined: round-robin grant when both valid; the last-served requester loses, and the pointer updates on accept.
REQ-029 MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, LS always beats IF; no pointer register.

Structure
REQ-030 Shared package mem_arb_types holds the owner_t enum (OWNER_IF, OWNER_LS) and the state_t enum (IDLE, ISSUE, WAIT).
REQ-031 Sub-module arb_grant2 holds the grant logic: inputs are two valids and the pointer; output is a one-hot grant. It contains the macro-selected behaviour.
REQ-032 Widths come from the `ALEN and `XLEN params header; no other parameters.

Verification
REQ-033 Single LS store, addr 0x100, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready=1, response after 1 cycle -> mem_write=1 at ISSUE; ls_resp_valid one pulse; if_resp_valid never asserted.
REQ-034 Both valid continuously for 4 transactions -> round-robin grants LS,IF,LS,IF (pointer IF-last at reset); with the macro undefined, grants are LS,LS,LS,LS.
REQ-035 Fetch 0x2000 with mem_req_ready held low 5 cycles -> mem_req_valid and mem_addr=0x2000 stable for all 5 cycles; handshake on cycle 6.
REQ-036 if_flush pulsed in WAIT of a fetch, memory returns 0x13 -> no if_resp_valid; FSM reaches IDLE; the next fetch is served normally.
REQ-037 mem_resp_fault=1 on an LS load -> ls_resp_fault=1 with ls_resp_valid; the arbiter continues.
REQ-038 rst asserted in WAIT, then a late mem_resp_valid -> no resp_valid on either port; state=IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: ALEN/XLEN width macros plus the shared mem_arb_types package.
// Widths may be overridden by defining ALEN/XLEN before this file is read.
`ifndef ALEN
`define ALEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package mem_arb_types;
    typedef enum logic {OWNER_IF, OWNER_LS} owner_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load-store and shared memory port signals.
// slave is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if;
    logic               if_req_valid, if_req_ready, if_flush;
    logic [`ALEN-1:0]   if_req_addr;
    logic               if_resp_valid, if_resp_fault;
    logic [`XLEN-1:0]   if_resp_data;
    logic               ls_req_valid, ls_req_ready, ls_req_write;
    logic [`ALEN-1:0]   ls_req_addr;
    logic [`XLEN-1:0]   ls_req_wdata;
    logic [`XLEN/8-1:0] ls_req_wmask;
    logic               ls_resp_valid, ls_resp_fault;
    logic [`XLEN-1:0]   ls_resp_data;
    logic               mem_req_valid, mem_req_ready, mem_write;
    logic [`ALEN-1:0]   mem_addr;
    logic [`XLEN-1:0]   mem_wdata;
    logic [`XLEN/8-1:0] mem_wmask;
    logic               mem_resp_valid, mem_resp_fault;
    logic [`XLEN-1:0]   mem_resp_data;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
               ls_req_valid, ls_req_addr, ls_req_write, ls_req_wdata, ls_req_wmask,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_fault,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_fault,
               ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_fault,
               mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wmask
    );
    modport master (
        output if_req_valid, if_req_addr, if_flush,
               ls_req_valid, ls_req_addr, ls_req_write, ls_req_wdata, ls_req_wmask,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_fault,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_fault,
               ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_fault,
               mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter_arb_grant2.sv
// arb_grant2: one-hot grant between IF (bit 0) and LS (bit 1).
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on i_last; otherwise LS has fixed priority.
module arb_grant2
    import mem_arb_types::*;
(
    input  logic [1:0] i_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t     i_last,
`endif
    output logic [1:0] o_grant
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb o_grant = &i_valid ? (i_last == OWNER_LS ? 2'b01 : 2'b10) : i_valid;
`else
    always_comb o_grant = i_valid[1] ? 2'b10 : i_valid;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load-store, one transaction in flight.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin grant; default is LS-over-IF fixed priority.
module mem_arbiter
    import mem_arb_types::*;
(
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    state_t             r_state, w_next;
    owner_t             r_owner;
    logic               r_drop, r_if_resp, r_ls_resp, r_write, r_fault;
    logic [`ALEN-1:0]   r_addr;
    logic [`XLEN-1:0]   r_wdata, r_rdata;
    logic [`XLEN/8-1:0] r_wmask;
    logic [1:0]         w_grant;
    logic               w_accept, w_done, w_take_ls;

    // a flushed fetch is never offered for grant
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t r_last;
    arb_grant2 u_grant (
        .i_valid ({bus.ls_req_valid, bus.if_req_valid & ~bus.if_flush}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );
    always_ff @(posedge clk)
        if (rst) r_last <= OWNER_IF;
        else if (w_accept) r_last <= w_take_ls ? OWNER_LS : OWNER_IF;
`else
    arb_grant2 u_grant (
        .i_valid ({bus.ls_req_valid, bus.if_req_valid & ~bus.if_flush}),
        .o_grant (w_grant)
    );
`endif

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_accept  = r_state == IDLE && !rst && |w_grant;
        w_take_ls = w_grant[1];
        w_done    = r_state == WAIT && bus.mem_resp_valid;
        w_next    = r_state == IDLE  ? (w_accept ? ISSUE : IDLE) :
                    r_state == ISSUE ? (bus.mem_req_ready ? WAIT : ISSUE) :
                                       (w_done ? IDLE : WAIT);
    end

    always_comb begin
        bus.if_req_ready  = w_accept & w_grant[0];
        bus.ls_req_ready  = w_accept & w_grant[1];
        bus.mem_req_valid = r_state == ISSUE;
        bus.mem_addr      = r_addr;
        bus.mem_write     = r_write;
        bus.mem_wdata     = r_wdata;
        bus.mem_wmask     = r_wmask;
        bus.if_resp_valid = r_if_resp;
        bus.if_resp_data  = r_rdata;
        bus.if_resp_fault = r_fault;
        bus.ls_resp_valid = r_ls_resp;
        bus.ls_resp_data  = r_rdata;
        bus.ls_resp_fault = r_fault;
    end

    // a flush landing in the response cycle itself suppresses the pulse directly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop    <= 1'b0;
            r_if_resp <= 1'b0;
            r_ls_resp <= 1'b0;
        end else begin
            r_if_resp <= w_done && r_owner == OWNER_IF && !r_drop && !bus.if_flush;
            r_ls_resp <= w_done && r_owner == OWNER_LS;
            r_drop    <= r_state != IDLE && w_next != IDLE &&
                         (r_drop || (bus.if_flush && r_owner == OWNER_IF));
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_owner <= w_take_ls ? OWNER_LS : OWNER_IF;
            r_addr  <= w_take_ls ? bus.ls_req_addr : bus.if_req_addr;
            r_write <= w_take_ls & bus.ls_req_write;
            r_wdata <= bus.ls_req_wdata;
            r_wmask <= w_take_ls ? bus.ls_req_wmask : '0;
        end
        if (w_done) begin
            r_rdata <= bus.mem_resp_data;
            r_fault <= bus.mem_resp_fault;
        end
    end
endmodule
